// File: rtl/alu_ctrl_if.sv
// ---------------------------------------------------------------------------
// alu_ctrl_if : instruction-fetch and ALU-control bundle for the Simple CPU.
//
//   imem_req  master->slave  fetch request (registered in the controller)
//   imem_ack  slave->master  instruction valid on instr this cycle
//   instr     slave->master  [11:8] opcode, [7:0] imm/address
//   pc        master->slave  current fetch address
//   alu_op    master->slave  ALU function select
//   imm       master->slave  operand to ALU b
//   acc_we    master->slave  accumulator write-enable, one cycle
//   alu_carry slave->master  ALU carry/borrow (bit 8 of result)
//   alu_zero  slave->master  ALU zero flag
//
// master = control unit, slave = instruction memory + datapath.
// ---------------------------------------------------------------------------
interface alu_ctrl_if;
  localparam int unsigned INSTR_W = 12;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned OP_W    = 5;

  logic               imem_req;
  logic               imem_ack;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  pc;
  logic [OP_W-1:0]    alu_op;
  logic [ADDR_W-1:0]  imm;
  logic               acc_we;
  logic               alu_carry;
  logic               alu_zero;

  modport master (
    output imem_req, pc, alu_op, imm, acc_we,
    input  imem_ack, instr, alu_carry, alu_zero
  );

  modport slave (
    input  imem_req, pc, alu_op, imm, acc_we,
    output imem_ack, instr, alu_carry, alu_zero
  );
endinterface

// File: rtl/alu_ctrl.sv
// ---------------------------------------------------------------------------
// alu_ctrl : multi-cycle control unit for the Simple CPU.
//   Fetches 12-bit instructions over a req/ack port, decodes them, drives the
//   ALU opcode/immediate/accumulator write-enable, latches carry/zero flags
//   and owns the program counter.
//
// Parameters
//   RESET_PC     PC value loaded on reset
//   ACK_TIMEOUT  max FETCH cycles with imem_req and no imem_ack; 0 = forever
//
// Ports
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   bus         alu_ctrl_if.master : imem_req/imem_ack/instr/pc,
//               alu_op/imm/acc_we, alu_carry/alu_zero
//   flag_c      registered carry flag
//   flag_z      registered zero flag
//   halted      core stopped (HLT or fault); exit only by reset
//   fault       sticky: fetch timeout (or illegal opcode when trapping)
//
// Optional feature
//   ALU_CTRL_ILLEGAL_TRAP_EN : when defined, opcodes 9..E in EXEC raise
//   fault and halt; otherwise they execute as NOP.
// ---------------------------------------------------------------------------
module alu_ctrl #(
  parameter logic [7:0]  RESET_PC    = 8'h00,
  parameter int unsigned ACK_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_ctrl_if.master  bus,
  output logic        flag_c,
  output logic        flag_z,
  output logic        halted,
  output logic        fault
);

  localparam int unsigned INSTR_W = 12;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned OP_W    = 5;
  localparam int unsigned OPC_W   = 4;

  // Timeout counter only needs to reach ACK_TIMEOUT-1.
  localparam int unsigned CNT_W      = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam bit          TIMEOUT_EN = (ACK_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((ACK_TIMEOUT == 0) ? 32'd0 : ACK_TIMEOUT - 32'd1);

  // ALU function encodings
  localparam logic [OP_W-1:0] ALU_ADD    = 5'b00000;
  localparam logic [OP_W-1:0] ALU_AND    = 5'b00001;
  localparam logic [OP_W-1:0] ALU_PASS_A = 5'b00010;
  localparam logic [OP_W-1:0] ALU_PASS_B = 5'b00011;
  localparam logic [OP_W-1:0] ALU_SUB    = 5'b01100;
  localparam logic [OP_W-1:0] ALU_INC    = 5'b10100;

  // Instruction opcodes
  localparam logic [OPC_W-1:0] OPC_NOP = 4'h0;
  localparam logic [OPC_W-1:0] OPC_ADD = 4'h1;
  localparam logic [OPC_W-1:0] OPC_AND = 4'h2;
  localparam logic [OPC_W-1:0] OPC_LDI = 4'h3;
  localparam logic [OPC_W-1:0] OPC_SUB = 4'h4;
  localparam logic [OPC_W-1:0] OPC_INC = 4'h5;
  localparam logic [OPC_W-1:0] OPC_JMP = 4'h6;
  localparam logic [OPC_W-1:0] OPC_JZ  = 4'h7;
  localparam logic [OPC_W-1:0] OPC_JC  = 4'h8;
  localparam logic [OPC_W-1:0] OPC_HLT = 4'hF;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALT   = 2'd3
  } state_e;

  state_e              state_q,   state_d;
  logic [ADDR_W-1:0]   pc_q,      pc_d;
  logic [INSTR_W-1:0]  instr_q,   instr_d;
  logic                imem_req_q, imem_req_d;
  logic [OP_W-1:0]     alu_op_q,  alu_op_d;
  logic [ADDR_W-1:0]   imm_q,     imm_d;
  logic                acc_we_q,  acc_we_d;
  logic                flag_c_q,  flag_c_d;
  logic                flag_z_q,  flag_z_d;
  logic                halted_q,  halted_d;
  logic                fault_q,   fault_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;

  logic [OPC_W-1:0]    opc;
  logic                is_alu;
  logic [OP_W-1:0]     dec_op;

  assign opc = instr_q[INSTR_W-1:ADDR_W];

  // Opcode -> ALU function; non-ALU opcodes leave the ALU on PASS_A.
  always_comb begin
    is_alu = 1'b1;
    dec_op = ALU_PASS_A;
    case (opc)
      OPC_ADD: dec_op = ALU_ADD;
      OPC_AND: dec_op = ALU_AND;
      OPC_LDI: dec_op = ALU_PASS_B;
      OPC_SUB: dec_op = ALU_SUB;
      OPC_INC: dec_op = ALU_INC;
      default: is_alu = 1'b0;
    endcase
  end

  // State register and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      imem_req_q <= 1'b0;
      alu_op_q   <= ALU_PASS_A;
      imm_q      <= '0;
      acc_we_q   <= 1'b0;
      flag_c_q   <= 1'b0;
      flag_z_q   <= 1'b0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      imem_req_q <= imem_req_d;
      alu_op_q   <= alu_op_d;
      imm_q      <= imm_d;
      acc_we_q   <= acc_we_d;
      flag_c_q   <= flag_c_d;
      flag_z_q   <= flag_z_d;
      halted_q   <= halted_d;
      fault_q    <= fault_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    imem_req_d = 1'b0;
    alu_op_d   = ALU_PASS_A;
    imm_d      = imm_q;
    acc_we_d   = 1'b0;
    flag_c_d   = flag_c_q;
    flag_z_d   = flag_z_q;
    halted_d   = halted_q;
    fault_d    = fault_q;
    cnt_d      = '0;

    unique case (state_q)
      ST_FETCH: begin
        // Request rises one cycle after FETCH entry; ack counts only with req up.
        imem_req_d = 1'b1;
        if (imem_req_q && bus.imem_ack) begin
          instr_d    = bus.instr;
          pc_d       = pc_q + ADDR_W'(1);
          imem_req_d = 1'b0;
          state_d    = ST_DECODE;
        end else if (imem_req_q && TIMEOUT_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == TO_LAST) begin
            imem_req_d = 1'b0;
            fault_d    = 1'b1;
            halted_d   = 1'b1;
            state_d    = ST_HALT;
          end
        end
      end

      ST_DECODE: begin
        // Registered here so opcode/imm/write-enable are stable through EXEC.
        alu_op_d = dec_op;
        imm_d    = instr_q[ADDR_W-1:0];
        acc_we_d = is_alu;
        state_d  = ST_EXEC;
      end

      ST_EXEC: begin
        state_d = ST_FETCH;
        case (opc)
          OPC_ADD, OPC_AND, OPC_LDI, OPC_SUB, OPC_INC: begin
            flag_c_d = bus.alu_carry;
            flag_z_d = bus.alu_zero;
          end
          OPC_NOP: ;
          OPC_JMP: pc_d = imm_q;
          OPC_JZ:  if (flag_z_q) pc_d = imm_q;
          OPC_JC:  if (flag_c_q) pc_d = imm_q;
          OPC_HLT: begin
            halted_d = 1'b1;
            state_d  = ST_HALT;
          end
          default: begin
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
            fault_d  = 1'b1;
            halted_d = 1'b1;
            state_d  = ST_HALT;
`else
            state_d  = ST_FETCH;
`endif
          end
        endcase
      end

      ST_HALT: ;
    endcase
  end

  assign bus.imem_req = imem_req_q;
  assign bus.pc       = pc_q;
  assign bus.alu_op   = alu_op_q;
  assign bus.imm      = imm_q;
  assign bus.acc_we   = acc_we_q;
  assign flag_c       = flag_c_q;
  assign flag_z       = flag_z_q;
  assign halted       = halted_q;
  assign fault        = fault_q;

endmodule
